seq_detector: RTL

//   Parametrised serial bit-pattern detector: next generation of the single-input

---
 rtl/seq_detector_pkg.sv | 16 +
 rtl/seq_detector_if.sv | 21 ++
 rtl/seq_detector_sat_counter.sv | 26 ++
 rtl/seq_detector.sv | 105 ++++++++++
 4 files changed

// File: rtl/seq_detector_pkg.sv
// Shared types and helpers for the serial pattern detector.
//   state_e     : detector FSM states
//   fill_cnt_w  : width of a counter that must reach PATTERN_LEN inclusive
package seq_detector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ARMED = 2'd2
  } state_e;

  function automatic int fill_cnt_w(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/seq_detector_if.sv
// Sample/result bundle for seq_detector.
//   clear       : synchronous flush of history and match count
//   in_valid    : qualifies the serial bit
//   in          : serial data bit
//   match       : one-cycle pulse per detected pattern
//   match_count : saturating match total
//   primed      : history holds a full pattern's worth of bits
// master = stream source, slave = detector.
interface seq_detector_if #(
  parameter int CNT_W = 8
);
  logic             clear;
  logic             in_valid;
  logic             in;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             primed;

  modport master (output clear, in_valid, in, input  match, match_count, primed);
  modport slave  (input  clear, in_valid, in, output match, match_count, primed);
endinterface

// File: rtl/seq_detector_sat_counter.sv
// Saturating up-counter.
//   clock, reset : rising-edge clock, async active-low reset
//   i_clr        : synchronous clear (wins over i_en)
//   i_en         : count one step
//   o_cnt        : count value, holds at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 r_cnt <= '0;
    else if (i_clr)             r_cnt <= '0;
    else if (i_en && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detector.sv
// Serial bit-pattern detector with valid qualifier.
//   clock, reset : rising-edge clock, async active-low reset
//   bus          : seq_detector_if slave (clear/in_valid/in in,
//                  match/match_count/primed out)
// The newest bit enters history at bit 0, so PATTERN's MSB is the oldest bit.
// With OVERLAP=0 a match flushes history so the next match needs a full
// fresh pattern.
module seq_detector
  import seq_detector_pkg::*;
#(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
  parameter bit                     OVERLAP     = 1'b1,
  parameter int                     CNT_W       = 8
) (
  input  logic           clock,
  input  logic           reset,
  seq_detector_if.slave  bus
);

  localparam int             FW   = fill_cnt_w(PATTERN_LEN);
  localparam logic [FW-1:0]  FULL = FW'(PATTERN_LEN);

  logic [PATTERN_LEN-1:0] r_hist;
  logic [FW-1:0]          r_fill;
  logic                   r_match;
  logic                   r_primed;
  state_e                 r_state;

  logic [PATTERN_LEN-1:0] w_hist_nxt;
  logic [FW-1:0]          w_fill_nxt;
  logic                   w_sample;
  logic                   w_hit;
  logic                   w_flush;
  logic [PATTERN_LEN-1:0] w_hist_d;
  logic [FW-1:0]          w_fill_d;
  state_e                 w_state_nxt;
  logic [CNT_W-1:0]       w_count;

  // Candidate history/fill as if this sample were accepted.
  assign w_sample   = bus.in_valid && !bus.clear;
  assign w_hist_nxt = {r_hist[PATTERN_LEN-2:0], bus.in};
  assign w_fill_nxt = (r_fill == FULL) ? FULL : r_fill + 1'b1;
  assign w_hit      = w_sample && (w_hist_nxt == PATTERN) && (w_fill_nxt == FULL);
  assign w_flush    = w_hit && !OVERLAP;

  always_comb begin
    w_hist_d = r_hist;
    w_fill_d = r_fill;
    if (bus.clear || w_flush) begin
      w_hist_d = '0;
      w_fill_d = '0;
    end else if (w_sample) begin
      w_hist_d = w_hist_nxt;
      w_fill_d = w_fill_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hist   <= '0;
      r_fill   <= '0;
      r_match  <= 1'b0;
      r_primed <= 1'b0;
    end else begin
      r_hist   <= w_hist_d;
      r_fill   <= w_fill_d;
      r_match  <= w_hit;
      r_primed <= (w_fill_d == FULL);
    end
  end

  // FSM: tracks fill progress; ARMED means every further sample can match.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear) begin
      w_state_nxt = ST_IDLE;
    end else if (w_sample) begin
      unique case (r_state)
        ST_IDLE:  w_state_nxt = (w_fill_d == FULL) ? ST_ARMED : ST_FILL;
        ST_FILL:  w_state_nxt = (w_fill_d == FULL) ? ST_ARMED : ST_FILL;
        ST_ARMED: w_state_nxt = w_flush ? ST_FILL : ST_ARMED;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clock (clock),
    .reset (reset),
    .i_clr (bus.clear),
    .i_en  (w_hit),
    .o_cnt (w_count)
  );

  assign bus.match       = r_match;
  assign bus.match_count = w_count;
  assign bus.primed      = r_primed;

endmodule
